sample_feeder: RTL and testbench

SAMPLE_FEEDER -- requirements
Module: sample_feeder

---
 rtl/sample_feeder_if.sv | 8 +
 rtl/sample_feeder.sv | 74 +++++++
 tb/tb_sample_feeder.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_feeder_if.sv
// sample_feeder_if: valid/ready sample stream into the feeder.
interface sample_feeder_if #(parameter int BITS_PER_ELEM = 8);
  logic signed [BITS_PER_ELEM-1:0] s_data;
  logic s_valid;
  logic s_ready;
  modport master(output s_data, output s_valid, input s_ready);
  modport slave(input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/sample_feeder.sv
// sample_feeder: buffers samples and strobes them out at a fixed period with setup/high/low framing.
module sample_feeder #(
  parameter int BITS_PER_ELEM = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int HIGH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  sample_feeder_if.slave s,
  input  logic i_enable,
  input  logic [15:0] i_period,
  output logic signed [BITS_PER_ELEM-1:0] o_value,
  output logic o_data_clk,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic o_underrun,
  output logic [7:0] o_underrun_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, HIGH = 2'd2, LOW = 2'd3;
  localparam logic [15:0] SETUP_END = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] HIGH_END = 16'(SETUP_CYCLES + HIGH_CYCLES - 1);
  localparam logic [15:0] MIN_P = 16'(SETUP_CYCLES + HIGH_CYCLES + 1);
  logic [1:0] state;
  logic [15:0] cnt, period;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic signed [BITS_PER_ELEM-1:0] mem [FIFO_DEPTH];
  logic push, pop, avail, frame_end, underrun;
  assign s.s_ready = o_fifo_level < (AW+1)'(FIFO_DEPTH);
  assign push = s.s_valid && s.s_ready;
  assign avail = o_fifo_level != '0;
  // cnt runs from the pop edge, so one frame is exactly period cycles pop-to-pop
  assign frame_end = state == LOW && cnt == period - 16'd1;
  assign pop = i_enable && avail && (state == IDLE || frame_end);
  assign underrun = frame_end && i_enable && !avail;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= s.s_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      period <= MIN_P;
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_fifo_level <= '0;
      o_value <= '0;
      o_data_clk <= 1'b0;
      o_underrun <= 1'b0;
      o_underrun_count <= '0;
    end else begin
      o_underrun <= underrun;
      o_underrun_count <= o_underrun_count + 8'(underrun && o_underrun_count != 8'hFF);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        o_value <= mem[rd_ptr];
      end
      o_fifo_level <= o_fifo_level + (AW+1)'(push) - (AW+1)'(pop);
      cnt <= pop ? '0 : state == IDLE ? cnt : cnt + 16'd1;
      if (pop) begin
        state <= SETUP;
        period <= i_period < MIN_P ? MIN_P : i_period;
      end else if (state == SETUP && cnt == SETUP_END) begin
        state <= HIGH;
        o_data_clk <= 1'b1;
      end else if (state == HIGH && cnt == HIGH_END) begin
        state <= LOW;
        o_data_clk <= 1'b0;
      end else if (frame_end) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_sample_feeder.sv
// tb_sample_feeder: randomized scenario checks of sample_feeder against a timing/queue model.
module tb_sample_feeder;
  localparam int S = 1, H = 2;
  logic clk = 0, rst = 1, i_enable = 0;
  logic [15:0] i_period = 16'd10;
  logic signed [7:0] o_value;
  logic o_data_clk, o_underrun;
  logic [3:0] o_fifo_level;
  logic [7:0] o_underrun_count;
  int tests = 0, failed = 0, cyc = 0, n_rise = 0, n_under = 0;
  int rise_cyc [1024];
  logic [7:0] rise_val [1024];
  logic prev_dclk = 0;
  sample_feeder_if #(.BITS_PER_ELEM(8)) sif();
  sample_feeder dut (
    .clk(clk), .rst(rst), .s(sif), .i_enable(i_enable), .i_period(i_period),
    .o_value(o_value), .o_data_clk(o_data_clk), .o_fifo_level(o_fifo_level),
    .o_underrun(o_underrun), .o_underrun_count(o_underrun_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (o_data_clk && !prev_dclk && n_rise < 1024) begin
      rise_cyc[n_rise] = cyc;
      rise_val[n_rise] = o_value;
      n_rise++;
    end
    prev_dclk = o_data_clk;
    if (o_underrun) n_under++;
  end
  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  function automatic int eff_p(input int per);
    return per < S + H + 1 ? S + H + 1 : per;
  endfunction

  task automatic push(input logic [7:0] v, output int edge_cyc);
    logic ok = 0;
    sif.s_data = v;
    sif.s_valid = 1;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = sif.s_ready;
      @(negedge clk);
    end
    sif.s_valid = 0;
    edge_cyc = cyc;
    tests++;
    if (!ok) begin failed++; $display("FAIL push_accept got ready=0 exp 1"); end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    sif.s_valid = 0;
    sif.s_data = 0;
    rst = 1;
    wait_cycles(3);
    tests += 6;
    if (sif.s_ready !== 1'b1) begin failed++; $display("FAIL reset_ready got %b exp 1", sif.s_ready); end
    if (o_value !== 8'sd0) begin failed++; $display("FAIL reset_value got %h exp 00", o_value); end
    if (o_data_clk !== 1'b0) begin failed++; $display("FAIL reset_dclk got %b exp 0", o_data_clk); end
    if (o_fifo_level !== 4'd0) begin failed++; $display("FAIL reset_level got %0d exp 0", o_fifo_level); end
    if (o_underrun !== 1'b0) begin failed++; $display("FAIL reset_underrun got %b exp 0", o_underrun); end
    if (o_underrun_count !== 8'd0) begin failed++; $display("FAIL reset_count got %0d exp 0", o_underrun_count); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int t, p;
    logic exp_d, exp_u;
    i_period = 16'd10;
    i_enable = 1;
    p = eff_p(10);
    push(8'h7F, t);
    tests++;
    if (o_fifo_level !== 4'd1) begin failed++; $display("FAIL single_level got %0d exp 1", o_fifo_level); end
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_d = (k >= 1 + S) && (k < 1 + S + H);
      exp_u = (k == 1 + p);
      tests += 3;
      if (o_value !== 8'sh7F) begin failed++; $display("FAIL single_value k=%0d got %h exp 7f", k, o_value); end
      if (o_data_clk !== exp_d) begin failed++; $display("FAIL single_dclk k=%0d got %b exp %b", k, o_data_clk, exp_d); end
      if (o_underrun !== exp_u) begin failed++; $display("FAIL single_underrun k=%0d got %b exp %b", k, o_underrun, exp_u); end
    end
    tests++;
    if (o_underrun_count !== 8'd1) begin failed++; $display("FAIL single_count got %0d exp 1", o_underrun_count); end
  endtask

  task automatic test_stream(input int n, input int per, input bit fixed);
    logic [7:0] exp [$];
    logic [7:0] v;
    int t, br, bu, p;
    logic [7:0] c0;
    i_period = 16'(per);
    i_enable = 1;
    p = eff_p(per);
    br = n_rise;
    bu = n_under;
    c0 = o_underrun_count;
    for (int i = 0; i < n; i++) begin
      v = fixed ? ((i == 1) ? 8'h7F : 8'hC7) : 8'($urandom);
      exp.push_back(v);
      push(v, t);
      if (i < 2) begin
        tests++;
        if (o_fifo_level !== 4'd1) begin failed++; $display("FAIL stream_level i=%0d got %0d exp 1", i, o_fifo_level); end
      end
    end
    wait_cycles((n + 1) * p + 10);
    tests += 2;
    if (n_rise - br !== n) begin failed++; $display("FAIL stream_rises got %0d exp %0d", n_rise - br, n); end
    if (o_underrun_count !== c0 + 8'd1) begin failed++; $display("FAIL stream_count got %0d exp %0d", o_underrun_count, c0 + 8'd1); end
    for (int i = 0; i < n && br + i < n_rise; i++) begin
      tests++;
      if (rise_val[br + i] !== exp[i]) begin failed++; $display("FAIL stream_value i=%0d got %h exp %h", i, rise_val[br + i], exp[i]); end
      if (i > 0) begin
        tests++;
        if (rise_cyc[br + i] - rise_cyc[br + i - 1] !== p) begin
          failed++; $display("FAIL stream_spacing i=%0d got %0d exp %0d", i, rise_cyc[br + i] - rise_cyc[br + i - 1], p);
        end
      end
    end
    tests++;
    if (n_under - bu !== 1) begin failed++; $display("FAIL stream_underruns got %0d exp 1", n_under - bu); end
  endtask

  task automatic test_full_min_period;
    logic [7:0] exp [$];
    logic [7:0] v;
    int t, br, bu;
    i_enable = 0;
    i_period = 16'd0;
    br = n_rise;
    bu = n_under;
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom);
      exp.push_back(v);
      push(v, t);
    end
    tests += 2;
    if (o_fifo_level !== 4'd8) begin failed++; $display("FAIL full_level got %0d exp 8", o_fifo_level); end
    if (sif.s_ready !== 1'b0) begin failed++; $display("FAIL full_ready got %b exp 0", sif.s_ready); end
    v = 8'($urandom);
    exp.push_back(v);
    sif.s_data = v;
    sif.s_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests += 2;
      if (o_fifo_level !== 4'd8) begin failed++; $display("FAIL full_hold_level got %0d exp 8", o_fifo_level); end
      if (sif.s_ready !== 1'b0) begin failed++; $display("FAIL full_hold_ready got %b exp 0", sif.s_ready); end
    end
    i_enable = 1;
    @(negedge clk);
    tests += 2;
    if (o_fifo_level !== 4'd7) begin failed++; $display("FAIL full_pop_level got %0d exp 7", o_fifo_level); end
    if (sif.s_ready !== 1'b1) begin failed++; $display("FAIL full_pop_ready got %b exp 1", sif.s_ready); end
    @(negedge clk);
    sif.s_valid = 0;
    tests++;
    if (o_fifo_level !== 4'd8) begin failed++; $display("FAIL full_refill_level got %0d exp 8", o_fifo_level); end
    wait_cycles(20);
    tests++;
    if (n_under - bu !== 0) begin failed++; $display("FAIL full_early_underrun got %0d exp 0", n_under - bu); end
    wait_cycles(9 * 4 + 10);
    tests += 2;
    if (n_rise - br !== 9) begin failed++; $display("FAIL full_rises got %0d exp 9", n_rise - br); end
    if (n_under - bu !== 1) begin failed++; $display("FAIL full_underruns got %0d exp 1", n_under - bu); end
    for (int i = 0; i < 9 && br + i < n_rise; i++) begin
      tests++;
      if (rise_val[br + i] !== exp[i]) begin failed++; $display("FAIL full_value i=%0d got %h exp %h", i, rise_val[br + i], exp[i]); end
      if (i > 0) begin
        tests++;
        if (rise_cyc[br + i] - rise_cyc[br + i - 1] !== S + H + 1) begin
          failed++; $display("FAIL full_spacing i=%0d got %0d exp %0d", i, rise_cyc[br + i] - rise_cyc[br + i - 1], S + H + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int t, br;
    logic [7:0] v;
    bit seen = 0;
    i_enable = 0;
    i_period = 16'd10;
    for (int i = 0; i < 4; i++) push(8'($urandom), t);
    i_enable = 1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = o_data_clk;
    end
    tests += 2;
    if (!seen) begin failed++; $display("FAIL rstmid_strobe got 0 exp 1"); end
    if (o_fifo_level !== 4'd3) begin failed++; $display("FAIL rstmid_prelevel got %0d exp 3", o_fifo_level); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    tests += 6;
    if (o_value !== 8'sd0) begin failed++; $display("FAIL rstmid_value got %h exp 00", o_value); end
    if (o_data_clk !== 1'b0) begin failed++; $display("FAIL rstmid_dclk got %b exp 0", o_data_clk); end
    if (o_fifo_level !== 4'd0) begin failed++; $display("FAIL rstmid_level got %0d exp 0", o_fifo_level); end
    if (o_underrun !== 1'b0) begin failed++; $display("FAIL rstmid_underrun got %b exp 0", o_underrun); end
    if (o_underrun_count !== 8'd0) begin failed++; $display("FAIL rstmid_count got %0d exp 0", o_underrun_count); end
    if (sif.s_ready !== 1'b1) begin failed++; $display("FAIL rstmid_ready got %b exp 1", sif.s_ready); end
    br = n_rise;
    wait_cycles(20);
    tests++;
    if (n_rise - br !== 0) begin failed++; $display("FAIL rstmid_ghost_rises got %0d exp 0", n_rise - br); end
    v = 8'($urandom);
    push(v, t);
    wait_cycles(8);
    tests++;
    if (n_rise - br !== 1) begin failed++; $display("FAIL rstmid_new_rises got %0d exp 1", n_rise - br); end
    else begin
      tests++;
      if (rise_val[br] !== v) begin failed++; $display("FAIL rstmid_new_value got %h exp %h", rise_val[br], v); end
    end
    wait_cycles(15);
  endtask

  task automatic test_saturate;
    int t, expc;
    bit seen;
    i_enable = 1;
    i_period = 16'd0;
    expc = o_underrun_count;
    for (int i = 0; i < 300; i++) begin
      push(8'($urandom), t);
      seen = 0;
      for (int j = 0; j < 20 && !seen; j++) begin
        @(negedge clk);
        seen = o_underrun;
      end
      expc = expc < 255 ? expc + 1 : 255;
      tests += 2;
      if (!seen) begin failed++; $display("FAIL sat_pulse i=%0d got 0 exp 1", i); end
      if (o_underrun_count !== 8'(expc)) begin failed++; $display("FAIL sat_count i=%0d got %0d exp %0d", i, o_underrun_count, expc); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_stream(3, 10, 1);
    for (int r = 0; r < 4; r++) test_stream(2 + int'($urandom_range(0, 4)), int'($urandom_range(0, 12)), 0);
    test_full_min_period;
    test_reset_mid;
    test_saturate;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
